// File: rtl/uart_host_controller.sv
// uart_host_controller: paces stream bytes into the UART transmitter on Tick and drains received bytes into an RX FIFO.
// Optional `UART_HOST_ERROR_FILTER_EN: errored bytes are acknowledged but not stored, counted on o_error_drop_count.
module uart_host_controller #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int FRAME_TICKS     = 10
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [7:0]               i_write_data,
  input  logic                     i_write_valid,
  output logic                     o_write_ready,
  output logic [7:0]               o_read_data,
  output logic [2:0]               o_read_errors,
  output logic                     o_read_valid,
  input  logic                     i_read_ready,
  output logic [7:0]               o_uart_input_data,
  output logic                     o_uart_send_command,
  input  logic                     i_uart_tick,
  input  logic [7:0]               i_uart_output_data,
  input  logic [2:0]               i_uart_errors,
  input  logic                     i_uart_host_interrupt,
  output logic                     o_uart_host_acknowledge,
  output logic [FIFO_DEPTH_LOG2:0] o_tx_count,
  output logic [FIFO_DEPTH_LOG2:0] o_rx_count,
  output logic                     o_rx_overflow
`ifdef UART_HOST_ERROR_FILTER_EN
  , output logic [7:0]             o_error_drop_count
`endif
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(FRAME_TICKS + 1);
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_RELEASE} rx_state_t;
  logic [7:0]    r_tx_mem [DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_count;
  logic [TW-1:0] r_tick_count;
  logic [7:0]    r_uart_input_data;
  tx_state_t     r_tx_state, w_tx_next;
  logic          w_tx_push, w_tx_pop, w_frame_done;
  assign o_write_ready     = r_tx_count != CW'(DEPTH);
  assign w_tx_push         = i_write_valid & o_write_ready;
  assign w_tx_pop          = (r_tx_state == TX_IDLE) & (r_tx_count != '0);
  assign w_frame_done      = i_uart_tick & (r_tick_count == TW'(FRAME_TICKS - 1));
  assign o_tx_count        = r_tx_count;
  assign o_uart_input_data = r_uart_input_data;
  always_ff @(posedge i_clock)
    if (w_tx_push) r_tx_mem[r_tx_wp] <= i_write_data;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_wp           <= '0;
      r_tx_rp           <= '0;
      r_tx_count        <= '0;
      r_tick_count      <= '0;
      r_uart_input_data <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop) r_tx_rp <= r_tx_rp + PW'(1);
      if (w_tx_pop) r_uart_input_data <= r_tx_mem[r_tx_rp];
      r_tx_count   <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
      r_tick_count <= (r_tx_state == TX_SEND) ? '0 :
                      (r_tx_state == TX_WAIT && i_uart_tick) ? r_tick_count + TW'(1) : r_tick_count;
    end
  end
  always_ff @(posedge i_clock)
    r_tx_state <= i_reset ? TX_IDLE : w_tx_next;
  always_comb
    w_tx_next = (r_tx_state == TX_IDLE && w_tx_pop)     ? TX_SEND :
                (r_tx_state == TX_SEND)                 ? TX_WAIT :
                (r_tx_state == TX_WAIT && w_frame_done) ? TX_IDLE : r_tx_state;
  always_comb
    o_uart_send_command = r_tx_state == TX_SEND;
  logic [10:0]   r_rx_mem [DEPTH];
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_count;
  logic          r_rx_overflow;
  rx_state_t     r_rx_state, w_rx_next;
  logic          w_rx_pop, w_capture, w_filtered, w_rx_try, w_rx_push;
`ifdef UART_HOST_ERROR_FILTER_EN
  logic [7:0] r_error_drop_count;
  assign w_filtered         = |i_uart_errors;
  assign o_error_drop_count = r_error_drop_count;
  always_ff @(posedge i_clock)
    if (i_reset) r_error_drop_count <= '0;
    else if (w_capture && w_filtered && r_error_drop_count != 8'hFF) r_error_drop_count <= r_error_drop_count + 8'd1;
`else
  assign w_filtered = 1'b0;
`endif
  assign o_read_valid  = r_rx_count != '0;
  assign w_rx_pop      = o_read_valid & i_read_ready;
  assign w_capture     = (r_rx_state == RX_IDLE) & i_uart_host_interrupt;
  assign w_rx_try      = w_capture & ~w_filtered;
  // a pop in the same cycle frees the slot the push lands in
  assign w_rx_push     = w_rx_try & ((r_rx_count != CW'(DEPTH)) | w_rx_pop);
  assign o_rx_count    = r_rx_count;
  assign o_rx_overflow = r_rx_overflow;
  assign {o_read_errors, o_read_data} = r_rx_mem[r_rx_rp];
  always_ff @(posedge i_clock)
    if (w_rx_push) r_rx_mem[r_rx_wp] <= {i_uart_errors, i_uart_output_data};
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_wp       <= '0;
      r_rx_rp       <= '0;
      r_rx_count    <= '0;
      r_rx_overflow <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop) r_rx_rp <= r_rx_rp + PW'(1);
      if (w_rx_try && !w_rx_push) r_rx_overflow <= 1'b1;
      r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end
  always_ff @(posedge i_clock)
    r_rx_state <= i_reset ? RX_IDLE : w_rx_next;
  always_comb
    w_rx_next = (r_rx_state == RX_IDLE && i_uart_host_interrupt)     ? RX_ACK     :
                (r_rx_state == RX_ACK)                               ? RX_RELEASE :
                (r_rx_state == RX_RELEASE && !i_uart_host_interrupt) ? RX_IDLE    : r_rx_state;
  always_comb
    o_uart_host_acknowledge = r_rx_state == RX_ACK;
endmodule

// File: tb/tb_uart_host_controller.sv
// tb_uart_host_controller: directed and random stimulus checked every cycle against a queue-based timeline model.
module tb_uart_host_controller;
  localparam int L = 4, D = 16, FT = 10;
  logic clk = 0, rst = 1;
  logic [7:0] wdata = 0, uodata = 0, rdata, uidata;
  logic [2:0] uerr = 0, rerr;
  logic wvalid = 0, wready, rvalid, rready = 0, send, tick = 0, uint = 0, ack, ovf;
  logic [L:0] txc, rxc;
`ifdef UART_HOST_ERROR_FILTER_EN
  logic [7:0] dropc;
`endif
  uart_host_controller #(.FIFO_DEPTH_LOG2(L), .FRAME_TICKS(FT)) dut (
    .i_clock(clk), .i_reset(rst), .i_write_data(wdata), .i_write_valid(wvalid), .o_write_ready(wready),
    .o_read_data(rdata), .o_read_errors(rerr), .o_read_valid(rvalid), .i_read_ready(rready),
    .o_uart_input_data(uidata), .o_uart_send_command(send), .i_uart_tick(tick),
    .i_uart_output_data(uodata), .i_uart_errors(uerr), .i_uart_host_interrupt(uint),
    .o_uart_host_acknowledge(ack), .o_tx_count(txc), .o_rx_count(rxc), .o_rx_overflow(ovf)
`ifdef UART_HOST_ERROR_FILTER_EN
    , .o_error_drop_count(dropc)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int n_chk = 0, n_fail = 0, n_send = 0, n_ack = 0, tick_mode = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  logic [7:0] m_txq[$];
  logic [10:0] m_rxq[$];
  logic [7:0] m_data;
  bit m_free, m_busy, m_ovf, m_on = 0;
  int m_send_cyc, m_ack_cyc, m_ticks, m_drop;
  always @(negedge clk) begin
    int sz, rs;
    bit popr;
    if (m_on) begin
      chk("tx_count", int'(txc), m_txq.size());
      chk("write_ready", int'(wready), int'(m_txq.size() < D));
      chk("send_cmd", int'(send), int'(cyc == m_send_cyc));
      chk("input_data", int'(uidata), int'(m_data));
      chk("host_ack", int'(ack), int'(cyc == m_ack_cyc));
      chk("rx_count", int'(rxc), m_rxq.size());
      chk("read_valid", int'(rvalid), int'(m_rxq.size() > 0));
      chk("rx_overflow", int'(ovf), int'(m_ovf));
      if (m_rxq.size() > 0) chk("read_word", int'({rerr, rdata}), int'(m_rxq[0]));
`ifdef UART_HOST_ERROR_FILTER_EN
      chk("drop_count", int'(dropc), m_drop);
`endif
    end
    if (send === 1'b1) n_send++;
    if (ack === 1'b1) n_ack++;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_data = 0; m_free = 1; m_busy = 0; m_ovf = 0; m_drop = 0; m_ticks = 0;
      m_send_cyc = -10; m_ack_cyc = -10; m_on = 1;
    end else if (m_on) begin
      sz = m_txq.size();
      if (m_free && sz > 0) begin
        m_data = m_txq.pop_front(); m_send_cyc = cyc + 1; m_free = 0; m_ticks = 0;
      end else if (!m_free && cyc > m_send_cyc && tick) begin
        m_ticks++;
        if (m_ticks == FT) m_free = 1;
      end
      if (wvalid && sz < D) m_txq.push_back(wdata);
      rs = m_rxq.size();
      popr = rs > 0 && rready;
      if (popr) void'(m_rxq.pop_front());
      if (!m_busy && uint) begin
        m_busy = 1; m_ack_cyc = cyc + 1;
`ifdef UART_HOST_ERROR_FILTER_EN
        if (uerr != 0) begin
          if (m_drop < 255) m_drop++;
        end else
`endif
        if (rs < D || popr) m_rxq.push_back({uerr, uodata});
        else m_ovf = 1;
      end else if (m_busy && cyc > m_ack_cyc && !uint) m_busy = 0;
    end
  end
  initial forever begin
    @(posedge clk); #2;
    tick = tick_mode == 1 ? (cyc % 4 == 0) : tick_mode == 2 ? ($urandom_range(2) == 0) : 1'b0;
  end
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic write_byte(input logic [7:0] b, output int acc);
    wdata = b; wvalid = 1; acc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wready) begin acc = cyc; step(); wvalid = 0; return; end
      step();
    end
    chk("write_timeout", 0, 1);
    wvalid = 0;
  endtask
  task automatic wait_tx_drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_txq.size() == 0 && m_free) begin step(); return; end
    end
    chk("tx_drain_timeout", 0, 1);
  endtask
  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask
  initial begin
    int n, s0;
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, s0;
    step(2); rst = 0;
    tick_mode = 1; s0 = n_send;
    write_byte(8'hA5, n);
    @(negedge clk); chk("t1_no_send_n1", int'(send), 0);
    step(); @(negedge clk);
    chk("t1_send_n2", int'(send), 1);
    chk("t1_data", int'(uidata), 8'hA5);
    wait_tx_drain();
    chk("t1_sends", n_send - s0, 1);
    tick_mode = 0; s0 = n_send;
    for (int i = 0; i <= 16; i++) write_byte(8'(i), n);
    @(negedge clk);
    chk("t2_txcount", int'(txc), 16);
    chk("t2_wready", int'(wready), 0);
    step(); tick_mode = 1;
    wait_tx_drain();
    step(50);
    chk("t2_sends", n_send - s0, 17);
    s0 = n_ack;
    uodata = 8'h3C; uerr = 0; uint = 1;
    step(); @(negedge clk);
    chk("t3_rvalid", int'(rvalid), 1);
    chk("t3_rdata", int'(rdata), 8'h3C);
    chk("t3_ack", int'(ack), 1);
    chk("t3_rxcount", int'(rxc), 1);
    step(4); uint = 0; step(3);
    chk("t3_rxcount_hold", int'(rxc), 1);
    chk("t3_acks", n_ack - s0, 1);
    rready = 1; step(); rready = 0;
    @(negedge clk); chk("t3_popped", int'(rxc), 0);
    step(); s0 = n_ack;
    for (int i = 0; i < 17; i++) begin
      uodata = 8'($urandom); uerr = 3'($urandom); uint = 1; step(2); uint = 0; step(2);
    end
    @(negedge clk);
    chk("t4_rxcount", int'(rxc), 16);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_acks", n_ack - s0, 17);
    step(); rready = 1; step(16); rready = 0;
    @(negedge clk); chk("t4_drained", int'(rxc), 0);
    step(); do_reset();
    @(negedge clk); chk("t5_ovf_cleared", int'(ovf), 0);
    step();
    for (int i = 0; i < 16; i++) begin
      uodata = 8'($urandom); uerr = 0; uint = 1; step(); uint = 0; step(2);
    end
    uodata = 8'h77; uint = 1; rready = 1; step(); uint = 0; rready = 0; step(3);
    chk("t5_rxcount", int'(rxc), 16);
    chk("t5_ovf", int'(ovf), 0);
    rready = 1; step(16); rready = 0; step();
    tick_mode = 0;
    write_byte(8'h5A, n); step(3);
    uint = 1; uodata = 8'h11; step(3);
    rst = 1; uint = 0; step(); rst = 0;
    @(negedge clk);
    chk("t6_send", int'(send), 0);
    chk("t6_ack", int'(ack), 0);
    chk("t6_idata", int'(uidata), 0);
    chk("t6_ovf", int'(ovf), 0);
    chk("t6_txcount", int'(txc), 0);
    chk("t6_rxcount", int'(rxc), 0);
    chk("t6_rvalid", int'(rvalid), 0);
    chk("t6_wready", int'(wready), 1);
    step();
`ifdef UART_HOST_ERROR_FILTER_EN
    uerr = 3'b010; uodata = 8'h99; uint = 1; step(); uint = 0; uerr = 0; step(3);
    chk("t6_filter_drop", int'(dropc), 1);
    chk("t6_filter_nopush", int'(rxc), 0);
`endif
    tick_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      wvalid = $urandom_range(1); wdata = 8'($urandom);
      uint = $urandom_range(3) == 0; uodata = 8'($urandom);
      uerr = $urandom_range(3) == 0 ? 3'($urandom) : 3'b000;
      rready = $urandom_range(1);
      step();
    end
    wvalid = 0; uint = 0; rready = 1;
    wait_tx_drain(); step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
